audio_pwm_out: RTL and testbench
================================

Name: audio_pwm_out

Overview:
- Downstream audio stage: consumes the 4-bit note samples produced by the note-playback block and drives a single-bit PWM pin toward the speaker/RC filter.
- Buffers samples in a small FIFO so that sample-rate jitter across note changes does not glitch the output.
- Emits one PWM period per sample, with duty proportional to the sample value, and reports underrun.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, at least 2).
- PRESCALE, 1, clocks per PWM counter step (at least 1). One PWM period = 16*PRESCALE clocks.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  1 = PWM running; 0 = output idle
- sample_valid  in  1  upstream offers sample_data this cycle
- sample_data  in  4  unsigned sample, 4'h0..4'hF
- sample_ready  out  1  FIFO can accept; equals !full
- pwm_out  out  1  PWM output
- fifo_level  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH
- period_start  out  1  one-cycle pulse on the first clock of each PWM period
- underrun  out  1  sticky; set when a period boundary finds the FIFO empty

Behaviour:
- Reset (synchronous on rst=1) values:
  - pwm_out=0, period_start=0, underrun=0, fifo_level=0, sample_ready=1.
  - Internal: prescale counter=0, PWM counter cnt=0, duty=0, FIFO pointers=0.
- Push:
  - Occurs when sample_valid && sample_ready at a rising edge.
  - The sample is visible in the FIFO (fifo_level incremented) on the next cycle.
  - If sample_valid is high while full, the sample is dropped and no state changes. Upstream is responsible for holding it.
- sample_ready is derived from registered occupancy only. A pop in the same cycle does not make a full FIFO accept.
- Tick:
  - Asserted when the prescale counter equals PRESCALE-1; the prescale counter then wraps to 0.
  - With PRESCALE=1, tick is high every cycle.
- cnt is 4 bits and advances on each tick while enable=1, wrapping 15 to 0.
- Period boundary is the tick at which cnt==15. At that edge:
  - If FIFO is non-empty: pop the head into duty.
  - If FIFO is empty: duty holds its previous value and underrun is set.
  - period_start pulses high for the next clock; cnt becomes 0.
- Output: pwm_out is registered, pwm_out <= enable && (cnt_next < duty_next).
  - Sample 0 gives a constant low output.
  - Sample 15 gives 15 of 16 steps high.
  - There is never 100% duty.
- Latency:
  - A sample pushed into an empty FIFO takes effect in the first PWM period starting after the next boundary.
  - Its duty is visible on pwm_out on the first clock of that period.
- Simultaneous push and pop:
  - Both happen; fifo_level is unchanged.
  - If the FIFO is empty at the boundary, the pop is treated as underrun even if a push occurs that same cycle. The pushed sample is used at the following boundary.
- Pointer wrap: read and write pointers are clog2(DEPTH) bits and wrap naturally. full/empty come from fifo_level.
- enable=0:
  - Prescale counter, cnt and duty are forced to 0; pwm_out=0; no pops; period_start=0.
  - The FIFO still accepts pushes.
  - On enable rising, the first boundary occurs after 16*PRESCALE clocks. The first period runs with duty 0.
- underrun clears only on rst.
- rst mid-period: all state returns to reset values on the next edge and FIFO contents are discarded.

Decomposition:
- Shared package audio_pkg:
  - SAMPLE_W=4 and PWM_STEPS=16 constants.
  - A sample_t typedef (4-bit unsigned), also used by the ROM/playback side.
- Sub-module sample_fifo:
  - Synchronous FIFO with parameters DEPTH and width SAMPLE_W.
  - Ports push/pop/din/dout/level/full/empty.
- The PWM counter, prescaler and duty register stay in the top of audio_pwm_out.

Test Plan:
- Reset, then hold enable=1 with no pushes:
  - pwm_out stays 0, and underrun=1 after the first boundary at clock 16 (PRESCALE=1).
  - period_start pulses every 16 clocks.
- Push 4'h8 while enable=0, then raise enable:
  - First period is all low.
  - Next period has pwm_out high for exactly 8 clocks, then low for 8.
  - fifo_level goes 1 to 0 at the boundary.
- Push 4'hF then 4'h0:
  - Consecutive periods show 15 high and 1 low, then 16 low.
  - underrun stays 0 until the FIFO drains.
- Push 5 samples back-to-back with DEPTH=4 and no pops:
  - sample_ready drops after the 4th push and fifo_level=4.
  - The 5th sample is not stored; the popped order is the first 4 samples.
- Full FIFO, hold sample_valid across a boundary pop:
  - The held sample is accepted in the cycle after the pop.
  - fifo_level returns to 4.
- PRESCALE=3, sample 4'h5:
  - Period is 48 clocks with 15 clocks high.
- Assert rst mid-period:
  - All outputs return to reset values on the next clock and the FIFO is empty.

Source files
------------

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio sample types and constants
package audio_pkg;

    localparam int SAMPLE_W  = 4;
    localparam int PWM_STEPS = 16;

    typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous sample FIFO feeding the PWM stage
// clk/rst: clock, synchronous active-high reset
// push/din: write request and data (ignored while full)
// pop/dout: read request (ignored while empty), head of queue (combinational)
// level/full/empty: registered occupancy and flags derived from it
module sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [SAMPLE_W-1:0]      din,
    output logic [SAMPLE_W-1:0]      dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    sample_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset; occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/audio_pwm_out.sv
// rtl/audio_pwm_out.sv - buffered 4-bit sample to single-bit PWM output
// clk/rst: clock, synchronous active-high reset
// enable: run the PWM; when low the output idles and the FIFO still fills
// sample_valid/sample_data/sample_ready: upstream sample handshake
// pwm_out: registered PWM pin, one 16-step period per sample
// fifo_level: FIFO occupancy 0..DEPTH
// period_start: one-clock pulse on the first clock of each period
// underrun: sticky, set when a period boundary finds the FIFO empty
module audio_pwm_out
    import audio_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     sample_valid,
    input  logic [SAMPLE_W-1:0]      sample_data,
    output logic                     sample_ready,
    output logic                     pwm_out,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     period_start,
    output logic                     underrun
);

    localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE - 1);
    localparam sample_t CNT_LAST = sample_t'(PWM_STEPS - 1);

    logic [PSC_W-1:0] psc;
    logic [PSC_W-1:0] psc_next;
    sample_t          cnt;
    sample_t          cnt_next;
    sample_t          duty;
    sample_t          duty_next;
    sample_t          fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             tick;
    logic             boundary;
    logic             pop;

    assign sample_ready = !fifo_full;

    sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (sample_valid),
        .pop   (pop),
        .din   (sample_data),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        tick      = (psc == PSC_MAX);
        boundary  = enable && tick && (cnt == CNT_LAST);
        // An empty FIFO at the boundary is an underrun even if a push lands
        // on the same edge; that sample waits for the next boundary.
        pop       = boundary && !fifo_empty;
        psc_next  = '0;
        cnt_next  = '0;
        duty_next = '0;
        if (enable) begin
            psc_next  = tick ? '0 : psc + PSC_W'(1);
            cnt_next  = tick ? cnt + sample_t'(1) : cnt;
            duty_next = pop ? fifo_dout : duty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            psc          <= '0;
            cnt          <= '0;
            duty         <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            psc          <= psc_next;
            cnt          <= cnt_next;
            duty         <= duty_next;
            // Comparing next-state values lines the output up with the new
            // period on its very first clock.
            pwm_out      <= enable && (cnt_next < duty_next);
            period_start <= boundary;
            if (boundary && fifo_empty) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_audio_pwm_out.sv
// tb/tb_audio_pwm_out.sv - self-checking bench for audio_pwm_out
module tb_audio_pwm_out;
    import audio_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable, sample_valid;
    logic [3:0] sample_data;
    logic       sample_ready, pwm_out, period_start, underrun;
    logic [2:0] fifo_level;

    logic       enable3, valid3;
    logic [3:0] data3;
    logic       ready3, pwm3, ps3, ur3;
    logic [2:0] level3;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    audio_pwm_out #(.DEPTH(4), .PRESCALE(1)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .sample_ready(sample_ready), .pwm_out(pwm_out),
        .fifo_level(fifo_level), .period_start(period_start),
        .underrun(underrun)
    );

    audio_pwm_out #(.DEPTH(4), .PRESCALE(3)) dut3 (
        .clk(clk), .rst(rst), .enable(enable3),
        .sample_valid(valid3), .sample_data(data3),
        .sample_ready(ready3), .pwm_out(pwm3),
        .fifo_level(level3), .period_start(ps3),
        .underrun(ur3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable = 0; sample_valid = 0; sample_data = 0;
        enable3 = 0; valid3 = 0; data3 = 0;
        rst = 1;
        step();
        rst = 0;
        exp_q.delete();
    endtask

    task automatic push_sample(input logic [3:0] v);
        sample_valid = 1; sample_data = v;
        exp_q.push_back(int'(v));
        step();
        sample_valid = 0;
    endtask

    task automatic measure_period(input int p, input bit use3,
                                  output int highs, output logic [15:0] pat);
        highs = 0;
        pat = '0;
        for (int i = 0; i < 16 * p; i++) begin
            logic b;
            b = use3 ? pwm3 : pwm_out;
            if (b) highs++;
            if (i % p == 0) pat[i / p] = b;
            step();
        end
    endtask

    function automatic logic [15:0] pat_of(input int e);
        logic [31:0] t;
        t = (32'd1 << e) - 32'd1;
        return t[15:0];
    endfunction

    task automatic test_reset();
        do_reset();
        n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL reset_pwm: got %0b want 0", pwm_out); end
        n_cmp++; if (period_start !== 1'b0) begin n_bad++; $display("FAIL reset_ps: got %0b want 0", period_start); end
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL reset_ur: got %0b want 0", underrun); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        n_cmp++; if (sample_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0b want 1", sample_ready); end
    endtask

    task automatic test_idle_underrun();
        int sum, extra, k;
        do_reset();
        enable = 1;
        sum = 0; extra = 0;
        for (int i = 1; i <= 15; i++) begin
            step();
            sum += int'(pwm_out);
            if (period_start !== 1'b0) extra++;
        end
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL idle_ur_early: got %0b want 0", underrun); end
        n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL idle_ps_early: got %0d pulses want 0", extra); end
        step();
        n_cmp++; if (period_start !== 1'b1) begin n_bad++; $display("FAIL idle_ps16: got %0b want 1", period_start); end
        n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL idle_ur16: got %0b want 1", underrun); end
        k = 0;
        do begin
            step();
            sum += int'(pwm_out);
            k++;
        end while (period_start !== 1'b1 && k < 40);
        n_cmp++; if (k != 16) begin n_bad++; $display("FAIL idle_period: got %0d clocks want 16", k); end
        n_cmp++; if (sum != 0) begin n_bad++; $display("FAIL idle_pwm: got %0d high want 0", sum); end
    endtask

    task automatic test_disabled_push();
        int sum, h, e;
        logic [15:0] pat;
        do_reset();
        push_sample(4'h8);
        n_cmp++; if (fifo_level !== 3'd1) begin n_bad++; $display("FAIL dis_level1: got %0d want 1", fifo_level); end
        enable = 1;
        sum = 0;
        for (int i = 1; i <= 15; i++) begin
            step();
            sum += int'(pwm_out);
        end
        n_cmp++; if (sum != 0) begin n_bad++; $display("FAIL dis_first_period: got %0d high want 0", sum); end
        step();
        n_cmp++; if (period_start !== 1'b1) begin n_bad++; $display("FAIL dis_ps: got %0b want 1", period_start); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL dis_level0: got %0d want 0", fifo_level); end
        measure_period(1, 0, h, pat);
        e = exp_q.pop_front();
        n_cmp++; if (h != e) begin n_bad++; $display("FAIL dis_highs: got %0d want %0d", h, e); end
        n_cmp++; if (pat !== pat_of(e)) begin n_bad++; $display("FAIL dis_pattern: got %h want %h", pat, pat_of(e)); end
    endtask

    task automatic test_full_then_zero();
        int h, e;
        logic [15:0] pat;
        do_reset();
        push_sample(4'hF);
        push_sample(4'h0);
        enable = 1;
        for (int i = 1; i <= 16; i++) step();
        for (int p = 0; p < 2; p++) begin
            n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL fz_ur_p%0d: got %0b want 0", p, underrun); end
            measure_period(1, 0, h, pat);
            e = exp_q.pop_front();
            n_cmp++; if (h != e) begin n_bad++; $display("FAIL fz_highs_p%0d: got %0d want %0d", p, h, e); end
            n_cmp++; if (pat !== pat_of(e)) begin n_bad++; $display("FAIL fz_pattern_p%0d: got %h want %h", p, pat, pat_of(e)); end
        end
        n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL fz_ur_drained: got %0b want 1", underrun); end
    endtask

    task automatic test_overflow();
        int model_lvl, h, e;
        logic [15:0] pat;
        do_reset();
        model_lvl = 0;
        for (int k = 1; k <= 5; k++) begin
            sample_valid = 1;
            sample_data = 4'(k);
            if (model_lvl < 4) begin
                exp_q.push_back(k);
                model_lvl++;
            end
            step();
            if (k == 4) begin
                n_cmp++; if (sample_ready !== 1'b0) begin n_bad++; $display("FAIL ovf_ready: got %0b want 0", sample_ready); end
            end
        end
        sample_valid = 0;
        n_cmp++; if (fifo_level !== 3'd4) begin n_bad++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
        enable = 1;
        for (int i = 1; i <= 16; i++) step();
        for (int p = 0; p < 4; p++) begin
            measure_period(1, 0, h, pat);
            e = exp_q.pop_front();
            n_cmp++; if (h != e) begin n_bad++; $display("FAIL ovf_highs_p%0d: got %0d want %0d", p, h, e); end
            n_cmp++; if (pat !== pat_of(e)) begin n_bad++; $display("FAIL ovf_pattern_p%0d: got %h want %h", p, pat, pat_of(e)); end
        end
        n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL ovf_fifth_dropped: underrun got %0b want 1", underrun); end
    endtask

    task automatic test_hold_across_pop();
        int h, e;
        logic [15:0] pat;
        do_reset();
        push_sample(4'h3);
        push_sample(4'h6);
        push_sample(4'h9);
        push_sample(4'hC);
        sample_valid = 1;
        sample_data = 4'h7;
        enable = 1;
        for (int i = 1; i <= 15; i++) step();
        n_cmp++; if (fifo_level !== 3'd4) begin n_bad++; $display("FAIL hold_level_full: got %0d want 4", fifo_level); end
        step();
        n_cmp++; if (fifo_level !== 3'd3) begin n_bad++; $display("FAIL hold_level_pop: got %0d want 3", fifo_level); end
        n_cmp++; if (sample_ready !== 1'b1) begin n_bad++; $display("FAIL hold_ready: got %0b want 1", sample_ready); end
        h = int'(pwm_out);
        step();
        sample_valid = 0;
        exp_q.push_back(7);
        n_cmp++; if (fifo_level !== 3'd4) begin n_bad++; $display("FAIL hold_level_refill: got %0d want 4", fifo_level); end
        for (int i = 1; i <= 15; i++) begin
            h += int'(pwm_out);
            step();
        end
        e = exp_q.pop_front();
        n_cmp++; if (h != e) begin n_bad++; $display("FAIL hold_highs_p0: got %0d want %0d", h, e); end
        for (int p = 1; p < 5; p++) begin
            measure_period(1, 0, h, pat);
            e = exp_q.pop_front();
            n_cmp++; if (h != e) begin n_bad++; $display("FAIL hold_highs_p%0d: got %0d want %0d", p, h, e); end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL hold_queue_left: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_prescale3();
        int h, e;
        logic [15:0] pat;
        do_reset();
        valid3 = 1; data3 = 4'h5;
        step();
        valid3 = 0;
        e = 5 * 3;
        enable3 = 1;
        for (int i = 1; i <= 47; i++) step();
        n_cmp++; if (ps3 !== 1'b0) begin n_bad++; $display("FAIL p3_ps47: got %0b want 0", ps3); end
        step();
        n_cmp++; if (ps3 !== 1'b1) begin n_bad++; $display("FAIL p3_ps48: got %0b want 1", ps3); end
        n_cmp++; if (level3 !== 3'd0) begin n_bad++; $display("FAIL p3_level: got %0d want 0", level3); end
        n_cmp++; if (ur3 !== 1'b0) begin n_bad++; $display("FAIL p3_ur: got %0b want 0", ur3); end
        measure_period(3, 1, h, pat);
        n_cmp++; if (h != e) begin n_bad++; $display("FAIL p3_highs: got %0d want %0d", h, e); end
        n_cmp++; if (ps3 !== 1'b1) begin n_bad++; $display("FAIL p3_period48: got %0b want 1", ps3); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        push_sample(4'hA);
        push_sample(4'h4);
        enable = 1;
        for (int i = 1; i <= 20; i++) step();
        n_cmp++; if (pwm_out !== 1'b1) begin n_bad++; $display("FAIL rm_pwm_before: got %0b want 1", pwm_out); end
        n_cmp++; if (fifo_level !== 3'd1) begin n_bad++; $display("FAIL rm_level_before: got %0d want 1", fifo_level); end
        rst = 1;
        step();
        rst = 0;
        exp_q.delete();
        n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL rm_pwm: got %0b want 0", pwm_out); end
        n_cmp++; if (period_start !== 1'b0) begin n_bad++; $display("FAIL rm_ps: got %0b want 0", period_start); end
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL rm_ur: got %0b want 0", underrun); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL rm_level: got %0d want 0", fifo_level); end
        n_cmp++; if (sample_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ready: got %0b want 1", sample_ready); end
        for (int i = 1; i <= 16; i++) step();
        n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL rm_fifo_discarded: underrun got %0b want 1", underrun); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1;
        enable = 0; sample_valid = 0; sample_data = 0;
        enable3 = 0; valid3 = 0; data3 = 0;
        step();
        test_reset();
        test_idle_underrun();
        test_disabled_push();
        test_full_then_zero();
        test_overflow();
        test_hold_across_pop();
        test_prescale3();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
